vreg_wport_arb: RTL and testbench

Write-port arbiter and sequencer for the vector register file (16 registers × 256-bit data plus 4-bit length, one write port with 1-cycle write latency). It shares that single write port between two producers: requester 0 is the vector ALU writeback and requester 1 is the vector load unit. Each requester has a one-entry holding buffer and a valid/ready handshake. The block also exports a per-register busy scoreboard that issue logic uses for RAW hazard checks.

---
 rtl/vreg_wport_arb_if.sv | 35 +++
 rtl/vreg_wport_arb.sv | 147 ++++++++++++++
 tb/tb_vreg_wport_arb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vreg_wport_arb_if.sv
// Write-port bundle between the two vector producers, the arbiter and the
// register file: request handshakes, write-port outputs, busy scoreboard, stall counters.
interface vreg_wport_arb_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [3:0]   req0_addr;
  logic [3:0]   req0_len;
  logic [255:0] req0_data;
  logic         req1_valid;
  logic         req1_ready;
  logic [3:0]   req1_addr;
  logic [3:0]   req1_len;
  logic [255:0] req1_data;
  logic         wEn;
  logic [3:0]   wAddr;
  logic [3:0]   wLen;
  logic [255:0] wData;
  logic [15:0]  busy;
  logic [15:0]  stall0_cnt;
  logic [15:0]  stall1_cnt;

  modport master (
    output req0_valid, req0_addr, req0_len, req0_data,
    output req1_valid, req1_addr, req1_len, req1_data,
    input  req0_ready, req1_ready,
    input  wEn, wAddr, wLen, wData, busy, stall0_cnt, stall1_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_len, req0_data,
    input  req1_valid, req1_addr, req1_len, req1_data,
    output req0_ready, req1_ready,
    output wEn, wAddr, wLen, wData, busy, stall0_cnt, stall1_cnt
  );
endinterface

// File: rtl/vreg_wport_arb.sv
// Two-producer write-port arbiter for the vector register file with per-register busy scoreboard.
// Optional stall counters are built when VREG_WARB_STATS_EN is defined.
module vreg_wport_arb (
  input  logic             clk,
  input  logic             rst,
  vreg_wport_arb_if.slave  bus
);

  logic         b0Valid_q, b0Valid_d, b1Valid_q, b1Valid_d;
  logic [3:0]   b0Addr_q, b0Addr_d, b1Addr_q, b1Addr_d;
  logic [3:0]   b0Len_q, b0Len_d, b1Len_q, b1Len_d;
  logic [255:0] b0Data_q, b0Data_d, b1Data_q, b1Data_d;
  logic         tie_q, tie_d;
  logic         older1_q, older1_d;
  logic         rr_q, rr_d;
  logic         both, grant0, grant1, load0, load1;

  // Age decides unless both buffers were loaded on the same edge, then rr breaks the tie.
  always_comb begin
    both   = b0Valid_q & b1Valid_q;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (both) begin
        grant1 = tie_q ? rr_q : older1_q;
        grant0 = !grant1;
      end else begin
        grant0 = b0Valid_q;
        grant1 = b1Valid_q;
      end
    end
  end

  assign bus.req0_ready = !rst && (!b0Valid_q || grant0);
  assign bus.req1_ready = !rst && (!b1Valid_q || grant1);
  assign load0 = bus.req0_valid && bus.req0_ready;
  assign load1 = bus.req1_valid && bus.req1_ready;

  always_comb begin
    b0Valid_d = load0 | (b0Valid_q & ~grant0);
    b1Valid_d = load1 | (b1Valid_q & ~grant1);
    b0Addr_d  = load0 ? bus.req0_addr : b0Addr_q;
    b0Len_d   = load0 ? bus.req0_len  : b0Len_q;
    b0Data_d  = load0 ? bus.req0_data : b0Data_q;
    b1Addr_d  = load1 ? bus.req1_addr : b1Addr_q;
    b1Len_d   = load1 ? bus.req1_len  : b1Len_q;
    b1Data_d  = load1 ? bus.req1_data : b1Data_q;
    tie_d     = tie_q;
    older1_d  = older1_q;
    rr_d      = rr_q;
    // The most recently loaded buffer is always the younger one.
    if (load0 && load1) begin
      tie_d = 1'b1;
    end else if (load0) begin
      tie_d    = 1'b0;
      older1_d = 1'b1;
    end else if (load1) begin
      tie_d    = 1'b0;
      older1_d = 1'b0;
    end
    if (both && grant0) rr_d = 1'b1;
    else if (both && grant1) rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b0Valid_q <= 1'b0;
      b1Valid_q <= 1'b0;
      b0Addr_q  <= '0;
      b0Len_q   <= '0;
      b0Data_q  <= '0;
      b1Addr_q  <= '0;
      b1Len_q   <= '0;
      b1Data_q  <= '0;
      tie_q     <= 1'b0;
      older1_q  <= 1'b0;
      rr_q      <= 1'b0;
    end else begin
      b0Valid_q <= b0Valid_d;
      b1Valid_q <= b1Valid_d;
      b0Addr_q  <= b0Addr_d;
      b0Len_q   <= b0Len_d;
      b0Data_q  <= b0Data_d;
      b1Addr_q  <= b1Addr_d;
      b1Len_q   <= b1Len_d;
      b1Data_q  <= b1Data_d;
      tie_q     <= tie_d;
      older1_q  <= older1_d;
      rr_q      <= rr_d;
    end
  end

  always_comb begin
    bus.wEn   = grant0 | grant1;
    bus.wAddr = '0;
    bus.wLen  = '0;
    bus.wData = '0;
    if (grant0) begin
      bus.wAddr = b0Addr_q;
      bus.wLen  = b0Len_q;
      bus.wData = b0Data_q;
    end else if (grant1) begin
      bus.wAddr = b1Addr_q;
      bus.wLen  = b1Len_q;
      bus.wData = b1Data_q;
    end
  end

  always_comb begin
    bus.busy = '0;
    if (!rst) begin
      for (int r = 0; r < 16; r++) begin
        bus.busy[r] = (b0Valid_q && (b0Addr_q == 4'(r))) ||
                      (b1Valid_q && (b1Addr_q == 4'(r)));
      end
    end
  end

`ifdef VREG_WARB_STATS_EN
  logic [15:0] stall0Cnt_q, stall0Cnt_d, stall1Cnt_q, stall1Cnt_d;

  // Counters saturate so a long stall never wraps back to a small value.
  always_comb begin
    stall0Cnt_d = stall0Cnt_q;
    stall1Cnt_d = stall1Cnt_q;
    if (b0Valid_q && !grant0 && (stall0Cnt_q != 16'hFFFF)) stall0Cnt_d = stall0Cnt_q + 16'd1;
    if (b1Valid_q && !grant1 && (stall1Cnt_q != 16'hFFFF)) stall1Cnt_d = stall1Cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall0Cnt_q <= '0;
      stall1Cnt_q <= '0;
    end else begin
      stall0Cnt_q <= stall0Cnt_d;
      stall1Cnt_q <= stall1Cnt_d;
    end
  end

  assign bus.stall0_cnt = rst ? 16'h0000 : stall0Cnt_q;
  assign bus.stall1_cnt = rst ? 16'h0000 : stall1Cnt_q;
`else
  assign bus.stall0_cnt = 16'h0000;
  assign bus.stall1_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vreg_wport_arb.sv
// Directed self-checking bench for vreg_wport_arb; expected stall counts follow VREG_WARB_STATS_EN.
module tb_vreg_wport_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compareCount = 0;
  int   mismatchCount = 0;

  vreg_wport_arb_if bus ();

  vreg_wport_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef VREG_WARB_STATS_EN
  localparam logic [15:0] EXP_STALL0 = 16'd4;
  localparam logic [15:0] EXP_STALL1 = 16'd5;
`else
  localparam logic [15:0] EXP_STALL0 = 16'd0;
  localparam logic [15:0] EXP_STALL1 = 16'd0;
`endif

  localparam logic [255:0] DA5 = {32{8'hA5}};
  localparam logic [255:0] D11 = {32{8'h11}};
  localparam logic [255:0] D22 = {32{8'h22}};
  localparam logic [255:0] DC1 = {8{32'hC001_0001}};
  localparam logic [255:0] DC2 = {8{32'hC002_0002}};
  localparam logic [255:0] DC3 = {8{32'hC003_0003}};
  localparam logic [255:0] DC4 = {8{32'hC004_0004}};

  task automatic checkOutput(input string tag, input logic [264:0] observed,
                             input logic [264:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] l0,
                               input logic [255:0] d0, input logic v1, input logic [3:0] a1,
                               input logic [3:0] l1, input logic [255:0] d1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_len   = l0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_len   = l1;
    bus.req1_data  = d1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 4'd0, '0, 1'b0, 4'd0, 4'd0, '0);
  endtask

  task automatic checkWrite(input string tag, input logic [3:0] a, input logic [3:0] l,
                            input logic [255:0] d);
    checkOutput(tag, {bus.wEn, bus.wAddr, bus.wLen, bus.wData}, {1'b1, a, l, d});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt0;
    int cnt1;
    logic f0;
    logic f1;
    logic [3:0] ea;
    logic [3:0] el;
    logic [255:0] ed;
    int item;

    idle();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_wEn", bus.wEn, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_ready0", bus.req0_ready, 0);
    checkOutput("rst_ready1", bus.req1_ready, 0);
    checkOutput("rst_stall0", bus.stall0_cnt, 0);
    checkOutput("rst_stall1", bus.stall1_cnt, 0);

    // Single write
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 4'd3, 4'd8, DA5, 1'b0, 4'd0, 4'd0, '0);
    #1;
    checkOutput("single_ready0", bus.req0_ready, 1);
    checkOutput("single_idle_wEn", bus.wEn, 0);
    @(negedge clk);
    idle();
    #1;
    checkWrite("single_write", 4'd3, 4'd8, DA5);
    checkOutput("single_busy", bus.busy, 16'h0008);
    @(negedge clk);
    #1;
    checkOutput("single_after_wEn", bus.wEn, 0);
    checkOutput("single_after_busy", bus.busy, 0);

    // Same-edge contention, rr starts at 0
    @(negedge clk);
    applyStimulus(1'b1, 4'd1, 4'd2, DC1, 1'b1, 4'd2, 4'd3, DC2);
    @(negedge clk);
    idle();
    #1;
    checkWrite("cont1_first", 4'd1, 4'd2, DC1);
    checkOutput("cont1_busy", bus.busy, 16'h0006);
    checkOutput("cont1_ready0", bus.req0_ready, 1);
    checkOutput("cont1_ready1", bus.req1_ready, 0);
    @(negedge clk);
    #1;
    checkWrite("cont1_second", 4'd2, 4'd3, DC2);
    checkOutput("cont1_busy2", bus.busy, 16'h0004);
    @(negedge clk);
    #1;
    checkOutput("cont1_done", bus.wEn, 0);
    @(negedge clk);
    applyStimulus(1'b1, 4'd1, 4'd4, DC3, 1'b1, 4'd2, 4'd5, DC4);
    @(negedge clk);
    idle();
    #1;
    checkWrite("cont2_first", 4'd2, 4'd5, DC4);
    @(negedge clk);
    #1;
    checkWrite("cont2_second", 4'd1, 4'd4, DC3);
    @(negedge clk);
    #1;
    checkOutput("cont2_done", bus.wEn, 0);

    // Same-register ordering
    @(negedge clk);
    applyStimulus(1'b0, 4'd0, 4'd0, '0, 1'b1, 4'd5, 4'd4, D11);
    @(negedge clk);
    applyStimulus(1'b1, 4'd5, 4'd6, D22, 1'b0, 4'd0, 4'd0, '0);
    #1;
    checkWrite("order_first", 4'd5, 4'd4, D11);
    checkOutput("order_busy1", bus.busy, 16'h0020);
    @(negedge clk);
    idle();
    #1;
    checkWrite("order_second", 4'd5, 4'd6, D22);
    checkOutput("order_busy2", bus.busy, 16'h0020);
    @(negedge clk);
    #1;
    checkOutput("order_done_wEn", bus.wEn, 0);
    checkOutput("order_done_busy", bus.busy, 0);

    // Reset with both buffers full
    @(negedge clk);
    applyStimulus(1'b1, 4'd7, 4'd1, DC1, 1'b1, 4'd9, 4'd1, DC2);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    checkOutput("mrst_wEn", bus.wEn, 0);
    checkOutput("mrst_busy", bus.busy, 0);
    checkOutput("mrst_ready0", bus.req0_ready, 0);
    checkOutput("mrst_ready1", bus.req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mrst_after_wEn", bus.wEn, 0);
    checkOutput("mrst_after_busy", bus.busy, 0);
    checkOutput("mrst_after_ready0", bus.req0_ready, 1);
    checkOutput("mrst_after_ready1", bus.req1_ready, 1);
    @(negedge clk);
    #1;
    checkOutput("mrst_later_wEn", bus.wEn, 0);

    // Streaming: five items per requester, rr back at 0 after reset
    cnt0 = 0;
    cnt1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      applyStimulus(cnt0 < 5, 4'(cnt0), 4'(cnt0 + 1), {8{32'h0A00_0000 + 32'(cnt0)}},
                    cnt1 < 5, 4'(8 + cnt1), 4'(cnt1 + 1), {8{32'h0B00_0000 + 32'(cnt1)}});
      #1;
      if (c == 0) begin
        checkOutput("stream_ready0_c0", bus.req0_ready, 1);
        checkOutput("stream_ready1_c0", bus.req1_ready, 1);
        checkOutput("stream_wEn_c0", bus.wEn, 0);
      end else if (c <= 10) begin
        item = (c - 1) / 2;
        if (c % 2 == 1) begin
          ea = 4'(item);
          ed = {8{32'h0A00_0000 + 32'(item)}};
        end else begin
          ea = 4'(8 + item);
          ed = {8{32'h0B00_0000 + 32'(item)}};
        end
        el = 4'(item + 1);
        checkWrite($sformatf("stream_write_c%0d", c), ea, el, ed);
        if (c <= 9) begin
          checkOutput($sformatf("stream_ready0_c%0d", c), bus.req0_ready, (c % 2 == 1) ? 1 : 0);
          checkOutput($sformatf("stream_ready1_c%0d", c), bus.req1_ready, (c % 2 == 0) ? 1 : 0);
        end
      end else begin
        checkOutput("stream_done_wEn", bus.wEn, 0);
        checkOutput("stream_stall0", bus.stall0_cnt, EXP_STALL0);
        checkOutput("stream_stall1", bus.stall1_cnt, EXP_STALL1);
      end
      f0 = bus.req0_valid & bus.req0_ready;
      f1 = bus.req1_valid & bus.req1_ready;
      @(posedge clk);
      if (f0) cnt0++;
      if (f1) cnt1++;
    end
    checkOutput("stream_sent0", 32'(cnt0), 5);
    checkOutput("stream_sent1", 32'(cnt1), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
